dfff_bank: RTL and testbench

Parametrised successor to the single-bit set/reset flip-flop: a WIDTH-bit register bank with per-bit synchronous set/clear masks, complementary outputs, and a mode-selected next-state function (load, shift, rotate, count). It is the general-purpose state element for the processor datapath, used for pipeline registers, shift registers and small counters. All state changes occur on the rising clock edge, except for the asynchronous active-low reset.

---
 rtl/dfff_pkg.sv | 18 +
 rtl/dfff_cell.sv | 43 ++++
 rtl/dfff_bank.sv | 98 +++++++++
 tb/tb_dfff_bank.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/dfff_pkg.sv
// Shared definitions for the dfff_bank register bank: mode encoding and
// the result type of the per-mode next-state computation.
package dfff_pkg;

  localparam int MODE_W = 3;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_LOAD = 3'b001;
  localparam mode_t MODE_SHL  = 3'b010;
  localparam mode_t MODE_SHR  = 3'b011;
  localparam mode_t MODE_ROTL = 3'b100;
  localparam mode_t MODE_ROTR = 3'b101;
  localparam mode_t MODE_INC  = 3'b110;
  localparam mode_t MODE_DEC  = 3'b111;

endpackage : dfff_pkg

// File: rtl/dfff_cell.sv
// One bit of the bank: asynchronous reset to RESET_BIT, synchronous clear
// over set over enabled next-state, otherwise hold.
module dfff_cell #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic r_n,
  input  logic clr,
  input  logic set,
  input  logic en,
  input  logic nxt,
  output logic q
);

  logic q_d;
  logic q_q;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 1'b0;
    end else if (set) begin
      q_d = 1'b1;
    end else if (en) begin
      q_d = nxt;
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      q_q <= RESET_BIT;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : dfff_cell

// File: rtl/dfff_bank.sv
// WIDTH-bit register bank with per-bit set/clear masks, complementary
// outputs and a mode-selected next-state function (load/shift/rotate/count).
module dfff_bank
  import dfff_pkg::*;
#(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              r_n,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              si,
  input  logic [WIDTH-1:0]  s_mask,
  input  logic [WIDTH-1:0]  r_mask,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  qbar,
  output logic              co
);

  logic [WIDTH-1:0] op_vec;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH:0]   dec_diff;
  logic             co_d;
  logic             co_q;

  // The extra top bit of each result is the wrap flag: carry on 1..1 -> 0,
  // borrow on 0 -> 1..1.
  assign inc_sum  = {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_diff = {1'b0, q} - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    op_vec = q;
    co_d   = co_q;
    if (en) begin
      co_d = 1'b0;
      unique case (mode)
        MODE_HOLD: op_vec = q;
        MODE_LOAD: op_vec = d;
        MODE_SHL: begin
          op_vec = {q[WIDTH-2:0], si};
          co_d   = q[WIDTH-1];
        end
        MODE_SHR: begin
          op_vec = {si, q[WIDTH-1:1]};
          co_d   = q[0];
        end
        MODE_ROTL: begin
          op_vec = {q[WIDTH-2:0], q[WIDTH-1]};
          co_d   = q[WIDTH-1];
        end
        MODE_ROTR: begin
          op_vec = {q[0], q[WIDTH-1:1]};
          co_d   = q[0];
        end
        MODE_INC: begin
          op_vec = inc_sum[WIDTH-1:0];
          co_d   = inc_sum[WIDTH];
        end
        MODE_DEC: begin
          op_vec = dec_diff[WIDTH-1:0];
          co_d   = dec_diff[WIDTH];
        end
        default: op_vec = q;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    dfff_cell #(
      .RESET_BIT(RESET_VAL[i])
    ) u_cell (
      .clk (clk),
      .r_n (r_n),
      .clr (r_mask[i]),
      .set (s_mask[i]),
      .en  (en),
      .nxt (op_vec[i]),
      .q   (q[i])
    );
  end

  // NOTE: reset is asynchronous and active-low; only the flops are reset,
  // all derived signals follow from them combinationally.
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      co_q <= 1'b0;
    end else begin
      co_q <= co_d;
    end
  end

  // qbar is a pure function of the stored q, so it can never disagree with it.
  assign qbar = ~q;
  assign co   = co_q;

endmodule : dfff_bank

// File: tb/tb_dfff_bank.sv
// Self-checking bench for dfff_bank (WIDTH=8, RESET_VAL=0): directed
// scenarios plus randomized traffic against an arithmetic reference model.
module tb_dfff_bank;

  logic       clk    = 1'b0;
  logic       r_n    = 1'b0;
  logic       en     = 1'b0;
  logic [2:0] mode   = 3'b000;
  logic [7:0] d      = 8'h00;
  logic       si     = 1'b0;
  logic [7:0] s_mask = 8'h00;
  logic [7:0] r_mask = 8'h00;
  logic [7:0] q;
  logic [7:0] qbar;
  logic       co;

  int tests  = 0;
  int fails  = 0;
  int exp_q  = 0;
  int exp_co = 0;

  always #5 clk = ~clk;

  dfff_bank #(
    .WIDTH    (8),
    .RESET_VAL(8'h00)
  ) dut (
    .clk   (clk),
    .r_n   (r_n),
    .en    (en),
    .mode  (mode),
    .d     (d),
    .si    (si),
    .s_mask(s_mask),
    .r_mask(r_mask),
    .q     (q),
    .qbar  (qbar),
    .co    (co)
  );

  // Drive one cycle of inputs at the falling edge, advance the reference
  // model, then return 1 time unit after the rising edge.
  task automatic drive_cycle(input logic e, input logic [2:0] m, input logic [7:0] dd,
                             input logic s_in, input logic [7:0] sm, input logic [7:0] rm);
    int op;
    int c;
    @(negedge clk);
    en = e; mode = m; d = dd; si = s_in; s_mask = sm; r_mask = rm;
    op = exp_q;
    c  = exp_co;
    if (e) begin
      case (m)
        3'd0: begin op = exp_q; c = 0; end
        3'd1: begin op = int'(dd); c = 0; end
        3'd2: begin op = ((exp_q * 2) + int'(s_in)) % 256; c = exp_q / 128; end
        3'd3: begin op = (int'(s_in) * 128) + (exp_q / 2); c = exp_q % 2; end
        3'd4: begin op = ((exp_q * 2) % 256) + (exp_q / 128); c = exp_q / 128; end
        3'd5: begin op = ((exp_q % 2) * 128) + (exp_q / 2); c = exp_q % 2; end
        3'd6: begin op = (exp_q + 1) % 256; c = (exp_q == 255) ? 1 : 0; end
        default: begin op = (exp_q + 255) % 256; c = (exp_q == 0) ? 1 : 0; end
      endcase
    end
    exp_q  = (op | int'(sm)) & ~int'(rm) & 255;
    exp_co = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests++; if (q !== 8'h00) begin fails++; $display("FAIL reset_q got %h want 00", q); end
    tests++; if (qbar !== 8'hFF) begin fails++; $display("FAIL reset_qbar got %h want ff", qbar); end
    tests++; if (co !== 1'b0) begin fails++; $display("FAIL reset_co got %b want 0", co); end
    @(negedge clk);
    r_n = 1'b1;
    drive_cycle(1'b1, 3'd1, 8'hA5, 1'b0, 8'h00, 8'h00);
    drive_cycle(1'b1, 3'd5, 8'h00, 1'b0, 8'h00, 8'h00);
    tests++; if (q !== 8'hD2 || co !== 1'b1) begin fails++; $display("FAIL pre_reset_rotr got %h/%b want d2/1", q, co); end
    @(negedge clk);
    #2;
    r_n = 1'b0;
    en = 1'b1; mode = 3'd1; d = 8'h77;
    #1;
    exp_q = 0; exp_co = 0;
    tests++; if (q !== 8'h00) begin fails++; $display("FAIL async_reset_q got %h want 00", q); end
    tests++; if (qbar !== 8'hFF) begin fails++; $display("FAIL async_reset_qbar got %h want ff", qbar); end
    tests++; if (co !== 1'b0) begin fails++; $display("FAIL async_reset_co got %b want 0", co); end
    @(posedge clk);
    #1;
    tests++; if (q !== 8'h00 || qbar !== 8'hFF) begin fails++; $display("FAIL reset_held got %h/%h want 00/ff", q, qbar); end
    @(negedge clk);
    r_n = 1'b1;
    en  = 1'b0;
    drive_cycle(1'b1, 3'd1, 8'h3C, 1'b0, 8'h00, 8'h00);
    tests++; if (q !== 8'h3C) begin fails++; $display("FAIL first_edge_load got %h want 3c", q); end
  endtask

  task automatic test_load();
    drive_cycle(1'b1, 3'd1, 8'hA5, 1'b0, 8'h00, 8'h00);
    tests++; if (q !== 8'hA5) begin fails++; $display("FAIL load_q got %h want a5", q); end
    tests++; if (qbar !== 8'h5A) begin fails++; $display("FAIL load_qbar got %h want 5a", qbar); end
    tests++; if (co !== 1'b0) begin fails++; $display("FAIL load_co got %b want 0", co); end
    drive_cycle(1'b0, 3'd1, 8'h11, 1'b0, 8'h00, 8'h00);
    tests++; if (q !== 8'hA5) begin fails++; $display("FAIL load_disabled got %h want a5", q); end
  endtask

  task automatic test_shift_rotate();
    drive_cycle(1'b1, 3'd1, 8'h81, 1'b0, 8'h00, 8'h00);
    drive_cycle(1'b1, 3'd2, 8'h00, 1'b1, 8'h00, 8'h00);
    tests++; if (q !== 8'h03 || co !== 1'b1) begin fails++; $display("FAIL shl got %h/%b want 03/1", q, co); end
    drive_cycle(1'b1, 3'd1, 8'h81, 1'b0, 8'h00, 8'h00);
    drive_cycle(1'b1, 3'd3, 8'h00, 1'b0, 8'h00, 8'h00);
    tests++; if (q !== 8'h40 || co !== 1'b1) begin fails++; $display("FAIL shr got %h/%b want 40/1", q, co); end
    drive_cycle(1'b1, 3'd1, 8'h81, 1'b0, 8'h00, 8'h00);
    drive_cycle(1'b1, 3'd5, 8'h00, 1'b0, 8'h00, 8'h00);
    tests++; if (q !== 8'hC0 || co !== 1'b1) begin fails++; $display("FAIL rotr got %h/%b want c0/1", q, co); end
    drive_cycle(1'b1, 3'd1, 8'h81, 1'b0, 8'h00, 8'h00);
    drive_cycle(1'b1, 3'd4, 8'h00, 1'b0, 8'h00, 8'h00);
    tests++; if (q !== 8'h03 || co !== 1'b1) begin fails++; $display("FAIL rotl got %h/%b want 03/1", q, co); end
  endtask

  task automatic test_count_wrap();
    drive_cycle(1'b1, 3'd1, 8'hFF, 1'b0, 8'h00, 8'h00);
    drive_cycle(1'b1, 3'd6, 8'h00, 1'b0, 8'h00, 8'h00);
    tests++; if (q !== 8'h00 || co !== 1'b1) begin fails++; $display("FAIL inc_wrap got %h/%b want 00/1", q, co); end
    drive_cycle(1'b1, 3'd6, 8'h00, 1'b0, 8'h00, 8'h00);
    tests++; if (q !== 8'h01 || co !== 1'b0) begin fails++; $display("FAIL inc_after_wrap got %h/%b want 01/0", q, co); end
    drive_cycle(1'b1, 3'd1, 8'h00, 1'b0, 8'h00, 8'h00);
    drive_cycle(1'b1, 3'd7, 8'h00, 1'b0, 8'h00, 8'h00);
    tests++; if (q !== 8'hFF || co !== 1'b1) begin fails++; $display("FAIL dec_wrap got %h/%b want ff/1", q, co); end
  endtask

  task automatic test_masks();
    drive_cycle(1'b1, 3'd1, 8'h0F, 1'b0, 8'h00, 8'h00);
    drive_cycle(1'b1, 3'd0, 8'h00, 1'b0, 8'hF0, 8'h11);
    tests++; if (q !== 8'hEE) begin fails++; $display("FAIL mask_priority got %h want ee", q); end
    // Leave co set, then check masks with en=0 neither touch it nor need en.
    drive_cycle(1'b1, 3'd1, 8'hFF, 1'b0, 8'h00, 8'h00);
    drive_cycle(1'b1, 3'd6, 8'h00, 1'b0, 8'h00, 8'h00);
    drive_cycle(1'b0, 3'd1, 8'h00, 1'b0, 8'hFF, 8'h00);
    tests++; if (q !== 8'hFF || co !== 1'b1) begin fails++; $display("FAIL mask_set_no_en got %h/%b want ff/1", q, co); end
    drive_cycle(1'b0, 3'd6, 8'h00, 1'b0, 8'h00, 8'h80);
    tests++; if (q !== 8'h7F || co !== 1'b1) begin fails++; $display("FAIL mask_clr_no_en got %h/%b want 7f/1", q, co); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [7:0] sm;
      logic [7:0] rm;
      sm = 8'($urandom_range(0, 3) == 0 ? ($urandom & $urandom & $urandom) : 0);
      rm = 8'($urandom_range(0, 3) == 0 ? ($urandom & $urandom & $urandom) : 0);
      drive_cycle(1'($urandom_range(0, 4) != 0), 3'($urandom), 8'($urandom),
                  1'($urandom), sm, rm);
      tests++;
      if (q !== 8'(exp_q) || qbar !== ~8'(exp_q) || co !== 1'(exp_co)) begin
        fails++;
        $display("FAIL random_%0d got q=%h qbar=%h co=%b want q=%h qbar=%h co=%0d",
                 i, q, qbar, co, 8'(exp_q), ~8'(exp_q), exp_co);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_shift_rotate();
    test_count_wrap();
    test_masks();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout after %0d tests", tests);
    $fatal(1, "watchdog");
  end

endmodule : tb_dfff_bank
